tx_fifo: RTL
============

TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, data word width in bits (UART byte).
REQ-002 SHALL have parameter LGDEPTH, default 4, log2 of entry count (depth 16).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_wr  input  1  write strobe from rx_uart valid.
REQ-006 SHALL have port i_wdata  input  DW  write data from rx_uart.
REQ-007 SHALL have port i_rd  input  1  consumer pop strobe, driven high when tx is idle.
REQ-008 SHALL have port o_valid  output  1  head entry present; data is valid on o_data.
REQ-009 SHALL have port o_data  output  DW  head entry, first-word-fall-through.
REQ-010 SHALL have port o_full  output  1  all 2**LGDEPTH entries occupied.
REQ-011 SHALL have port o_overflow  output  1  sticky flag: a write was dropped.

Function
REQ-012 SHALL keep write pointer, read pointer and occupancy count; pointers LGDEPTH bits, wrap modulo 2**LGDEPTH; count LGDEPTH+1 bits.
REQ-013 SHALL accept a write when i_wr is high and either not full or a pop occurs in the same cycle.
REQ-014 SHALL perform a pop when i_rd is high and o_valid is high; i_rd with o_valid low SHALL be ignored.
REQ-015 SHALL drive o_data from the head entry in the same cycle o_valid is high (FWFT); no added read latency.
REQ-016 SHALL make a write to an empty FIFO visible at o_valid/o_data one cycle after the write edge; no same-cycle bypass.
REQ-017 SHALL leave count unchanged on simultaneous accepted write and pop; otherwise count changes by +1 on write and -1 on pop.
REQ-018 SHALL assert o_full when count equals 2**LGDEPTH, and o_valid when count is nonzero, both registered or decoded from registered count.
REQ-019 SHALL drop a write when full with no same-cycle pop, leaving storage unchanged, and SHALL set o_overflow the next cycle.
REQ-020 SHALL hold o_overflow high until reset.
REQ-021 SHALL keep o_data stable while o_valid is high and no pop occurs.

Reset
REQ-022 SHALL, on an i_reset low clock edge, clear both pointers, count and o_overflow; o_valid=0, o_full=0, o_overflow=0 after that edge.
REQ-023 SHALL discard any stored entries on reset mid-operation; reset overrides concurrent i_wr/i_rd.
REQ-024 SHALL leave storage array contents unreset; o_data is don't-care while o_valid=0.

Configuration
REQ-025 SHALL, with macro TX_FIFO_FILL_EN defined, add output port o_fill (LGDEPTH+1 bits) equal to the current count, reset to 0.
REQ-026 SHALL, without TX_FIFO_FILL_EN, omit o_fill entirely; all other behaviour identical.

Structure
REQ-027 SHALL take default DW and LGDEPTH from shared package uart_pkg, alongside the existing baud/timer constants.
REQ-028 SHALL place storage in sub-module tx_fifo_mem: 2**LGDEPTH x DW, one synchronous write port, one asynchronous read port.
REQ-029 SHALL be instantiated between rx_uart (i_wr/i_wdata) and tx (o_valid/o_data), with i_rd = o_valid and tx not busy.

Verification
REQ-030 Reset then write 0x41 -> o_valid=1 one cycle later, o_data=0x41; pop -> o_valid=0, o_overflow=0.
REQ-031 Write 16 bytes 0x00..0x0F with no pops -> o_full=1 after 16th; pop 16 -> data 0x00..0x0F in order, o_valid=0 at end.
REQ-032 Full, write 0xAA with no pop -> byte dropped, o_overflow=1 next cycle and stays 1; drained data excludes 0xAA.
REQ-033 Full, write 0x55 with same-cycle pop -> accepted, o_full stays 1, o_overflow stays 0; 0x55 emerges last.
REQ-034 Write 20 and pop 20 interleaved so pointers wrap -> output order matches input, count returns to 0.
REQ-035 Fill 5 entries, assert i_reset low one cycle with i_wr high -> o_valid=0, count 0, o_fill=0 (TX_FIFO_FILL_EN build).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: baud/timer settings and default TX FIFO geometry.
// Also holds the FIFO operation encoding used by tx_fifo.
package uart_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int BAUD_RATE     = 115_200;
  localparam int CLKS_PER_BAUD = CLK_HZ / BAUD_RATE;
  localparam int BAUD_TIMER_W  = $clog2(CLKS_PER_BAUD + 1);

  localparam int FIFO_DW      = 8;
  localparam int FIFO_LGDEPTH = 4;

  // Bit 0 = accepted write, bit 1 = pop.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// TX FIFO storage: synchronous write port, asynchronous read port.
// Contents are deliberately never reset.
module tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DW      = FIFO_DW,
  parameter int LGDEPTH = FIFO_LGDEPTH
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [LGDEPTH-1:0] i_waddr,
  input  logic [DW-1:0]      i_wdata,
  input  logic [LGDEPTH-1:0] i_raddr,
  output logic [DW-1:0]      o_rdata
);

  logic [DW-1:0] mem [0:(1<<LGDEPTH)-1];

  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/tx_fifo.sv
// First-word-fall-through byte FIFO between rx_uart and tx, with sticky overflow.
// Define TX_FIFO_FILL_EN to expose the occupancy count on o_fill.
module tx_fifo
  import uart_pkg::*;
#(
  parameter int DW      = FIFO_DW,
  parameter int LGDEPTH = FIFO_LGDEPTH
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic [DW-1:0]    i_wdata,
  input  logic             i_rd,
  output logic             o_valid,
  output logic [DW-1:0]    o_data,
  output logic             o_full,
  output logic             o_overflow
`ifdef TX_FIFO_FILL_EN
  ,
  output logic [LGDEPTH:0] o_fill
`endif
);

  localparam logic [LGDEPTH:0]   FULL_COUNT = {1'b1, {LGDEPTH{1'b0}}};
  localparam logic [LGDEPTH:0]   CNT_ONE    = {{LGDEPTH{1'b0}}, 1'b1};
  localparam logic [LGDEPTH-1:0] PTR_ONE    = {{(LGDEPTH-1){1'b0}}, 1'b1};

  logic [LGDEPTH-1:0] wr_ptr;
  logic [LGDEPTH-1:0] rd_ptr;
  logic [LGDEPTH:0]   count;
  logic               overflow;
  logic               pop;
  logic               push;
  logic               drop;
  fifo_op_e           op;

  assign o_valid = (count != '0);
  assign o_full  = (count == FULL_COUNT);

  // A pop frees the head slot this cycle, so a write to a full FIFO is still taken.
  assign pop  = i_rd & o_valid;
  assign push = i_wr & (~o_full | pop);
  assign drop = i_wr & o_full & ~pop;
  assign op   = fifo_op(push, pop);

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (op)
        FIFO_PUSH: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          count  <= count + CNT_ONE;
        end
        FIFO_POP: begin
          rd_ptr <= rd_ptr + PTR_ONE;
          count  <= count - CNT_ONE;
        end
        FIFO_BOTH: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        default: ;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  assign o_overflow = overflow;

`ifdef TX_FIFO_FILL_EN
  assign o_fill = count;
`endif

  tx_fifo_mem #(
    .DW      (DW),
    .LGDEPTH (LGDEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (push),
    .i_waddr (wr_ptr),
    .i_wdata (i_wdata),
    .i_raddr (rd_ptr),
    .o_rdata (o_data)
  );

endmodule
